microprocessor_param: RTL and testbench

//  Parametrised successor of the team's 8-bit accumulator microprocessor. Two phases:
//   - Load phase: program and data words are entered through data_in/Enter into internal memory.
//   - Run phase: starts on testStart; fetch/execute runs until HALT.

---
 rtl/microprocessor_param.sv | 223 ++++++++++++++++++++++
 tb/tb_microprocessor_param.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microprocessor_param.sv
// Parametrised accumulator microprocessor: a load phase fills the shared program/data memory,
// then fetch/execute runs until HALT. Optional single-step mode: define MICROP_SINGLE_STEP_EN.
module microprocessor_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              Enter,
    input  logic              testStart,
    output logic [DATA_W-1:0] dataOut,
    output logic [2:0]        CheckState,
    output logic              Halt,
    output logic              Zero,
    output logic              Carry,
    output logic              loadFull
);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXEC    = 3'd2,
        S_WAIT_IN = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_JMP   = 4'd7,
        OP_JZ    = 4'd8,
        OP_OUT   = 4'd9,
        OP_IN    = 4'd10,
        OP_HALT  = 4'd15
    } opcode_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic                full_q, full_d;
    logic                enter_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                pulse;
    logic                fetch_go;
    opcode_t             op;
    logic [ADDR_W-1:0]   opnd_addr;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W:0]     sum_w;
    logic [DATA_W:0]     diff_w;
    logic [DATA_W-1:0]   and_w;
    logic [DATA_W-1:0]   or_w;
    logic [ADDR_W-1:0]   pc_inc;
    logic                unused_ir_bits;

    assign pulse     = Enter & ~enter_q;
    assign op        = opcode_t'(ir_q[DATA_W-1 -: 4]);
    assign opnd_addr = ir_q[ADDR_W-1:0];
    assign opnd      = mem_q[opnd_addr];
    assign sum_w     = {1'b0, acc_q} + {1'b0, opnd};
    // Bit DATA_W of the widened difference is the borrow out.
    assign diff_w    = {1'b0, acc_q} - {1'b0, opnd};
    assign and_w     = acc_q & opnd;
    assign or_w      = acc_q | opnd;
    assign pc_inc    = (pc_q == LAST_ADDR) ? '0 : pc_q + ADDR_W'(1);
    assign unused_ir_bits = ^ir_q;

`ifdef MICROP_SINGLE_STEP_EN
    assign fetch_go = pulse;
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ptr_d     = ptr_q;
        acc_d     = acc_q;
        ir_d      = ir_q;
        dout_d    = dout_q;
        z_d       = z_q;
        c_d       = c_q;
        full_d    = full_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = data_in;

        case (state_q)
            S_LOAD: begin
                if (pulse && !full_q) begin
                    mem_we = 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        full_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
                if (testStart) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end

            S_FETCH: begin
                if (fetch_go) begin
                    ir_d    = mem_q[pc_q];
                    pc_d    = pc_inc;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_LOAD: begin
                        acc_d = opnd;
                        z_d   = (opnd == '0);
                    end
                    OP_STORE: begin
                        mem_we    = 1'b1;
                        mem_waddr = opnd_addr;
                        mem_wdata = acc_q;
                    end
                    OP_ADD: begin
                        acc_d = sum_w[DATA_W-1:0];
                        c_d   = sum_w[DATA_W];
                        z_d   = (sum_w[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        acc_d = diff_w[DATA_W-1:0];
                        c_d   = diff_w[DATA_W];
                        z_d   = (diff_w[DATA_W-1:0] == '0);
                    end
                    OP_AND: begin
                        acc_d = and_w;
                        z_d   = (and_w == '0);
                    end
                    OP_OR: begin
                        acc_d = or_w;
                        z_d   = (or_w == '0);
                    end
                    OP_JMP:  pc_d = opnd_addr;
                    OP_JZ:   if (z_q) pc_d = opnd_addr;
                    OP_OUT:  dout_d = acc_q;
                    OP_IN:   state_d = S_WAIT_IN;
                    OP_HALT: state_d = S_HALT;
                    default: ;
                endcase
            end

            S_WAIT_IN: begin
                if (pulse) begin
                    acc_d   = data_in;
                    z_d     = (data_in == '0);
                    state_d = S_FETCH;
                end
            end

            S_HALT: ;

            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_LOAD;
            pc_q    <= '0;
            ptr_q   <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            dout_q  <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            full_q  <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            dout_q  <= dout_d;
            z_q     <= z_d;
            c_q     <= c_d;
            full_q  <= full_d;
            enter_q <= Enter;
        end
    end

    // Memory survives reset so a program can be rerun without reloading.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign dataOut    = dout_q;
    assign CheckState = state_q;
    assign Halt       = (state_q == S_HALT);
    assign Zero       = z_q;
    assign Carry      = c_q;
    assign loadFull   = full_q;

endmodule

// File: tb/tb_microprocessor_param.sv
// Scoreboard bench for microprocessor_param: an ISA-level model predicts OUT values and the
// final halt state; a monitor pops predictions whenever dataOut changes or Halt rises.
`timescale 1ns/1ps
module tb_microprocessor_param;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
`ifdef MICROP_SINGLE_STEP_EN
    localparam bit STEP = 1'b1;
`else
    localparam bit STEP = 1'b0;
`endif

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              Enter = 1'b0;
    logic              testStart = 1'b0;
    logic [DATA_W-1:0] dataOut;
    logic [2:0]        CheckState;
    logic              Halt, Zero, Carry, loadFull;

    microprocessor_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .data_in(data_in), .Enter(Enter),
        .testStart(testStart), .dataOut(dataOut), .CheckState(CheckState),
        .Halt(Halt), .Zero(Zero), .Carry(Carry), .loadFull(loadFull)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int t0 = 0;

    typedef struct {
        bit         is_halt;
        logic [7:0] dout;
        bit         z;
        bit         c;
        int         ncyc;
        bit         chk_cyc;
    } exp_t;
    exp_t sb[$];

    logic [7:0] img [16];
    logic [7:0] m_mem [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string detail);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // Monitor: consumes one prediction per observed output event.
    logic [7:0] mon_dout = '0;
    logic       mon_halt = 1'b0;
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset) begin
            mon_dout = '0;
            mon_halt = 1'b0;
        end else begin
            if (dataOut !== mon_dout) begin
                if (sb.size() == 0 || sb[0].is_halt) begin
                    check("unexpected_out", dataOut, mon_dout);
                end else begin
                    e = sb.pop_front();
                    check("out_value", dataOut, e.dout);
                end
                mon_dout = dataOut;
            end
            if (Halt && !mon_halt) begin
                if (sb.size() == 0 || !sb[0].is_halt) begin
                    fail_now("unexpected_halt", "got Halt=1 expected Halt=0");
                end else begin
                    e = sb.pop_front();
                    check("halt_dout", dataOut, e.dout);
                    check("halt_zero", Zero, e.z);
                    check("halt_carry", Carry, e.c);
                    check("halt_state", CheckState, 3'd4);
                    if (e.chk_cyc) check("halt_cycles", cyc - t0, e.ncyc);
                end
            end
            mon_halt = Halt;
        end
    end

    // ISA-level reference: executes the image instruction by instruction.
    task automatic model_and_expect(input logic [7:0] in_val, input bit chk_cyc);
        int a, z, c, pc, dout, n, w, op, ad, v;
        exp_t e;
        a = 0; z = 0; c = 0; pc = 0; dout = 0; n = 0;
        m_mem = img;
        for (int step = 0; step < 200; step++) begin
            w  = m_mem[pc];
            pc = (pc + 1) % DEPTH;
            n++;
            op = w / 16;
            ad = w % 16;
            v  = m_mem[ad];
            if (op == 15) break;
            case (op)
                1:  begin a = v; z = (a == 0); end
                2:  m_mem[ad] = 8'(a);
                3:  begin a = a + v; c = (a > 255); a = a % 256; z = (a == 0); end
                4:  begin c = (a < v); a = (a - v + 256) % 256; z = (a == 0); end
                5:  begin a = a & v; z = (a == 0); end
                6:  begin a = a | v; z = (a == 0); end
                7:  pc = ad;
                8:  if (z != 0) pc = ad;
                9:  begin
                        if (a != dout) begin
                            e = '{is_halt: 1'b0, dout: 8'(a), z: 1'b0, c: 1'b0, ncyc: 0, chk_cyc: 1'b0};
                            sb.push_back(e);
                        end
                        dout = a;
                    end
                10: begin a = in_val; z = (a == 0); end
                default: ;
            endcase
        end
        e = '{is_halt: 1'b1, dout: 8'(dout), z: (z != 0), c: (c != 0), ncyc: 2 * n,
              chk_cyc: chk_cyc && !STEP};
        sb.push_back(e);
    endtask

    task automatic step_pulse();
`ifdef MICROP_SINGLE_STEP_EN
        Enter = 1'b1;
        @(negedge Clock);
        Enter = 1'b0;
`endif
    endtask

    task automatic do_reset();
        Reset = 1'b0; Enter = 1'b0; testStart = 1'b0; data_in = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic pulse_word(input logic [7:0] v);
        @(negedge Clock);
        data_in = v;
        Enter = 1'b1;
        @(negedge Clock);
        Enter = 1'b0;
    endtask

    task automatic load_image();
        for (int i = 0; i < 16; i++) pulse_word(img[i]);
    endtask

    task automatic start_run();
        @(negedge Clock);
        testStart = 1'b1;
        @(posedge Clock);
        #1;
        t0 = cyc;
        testStart = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (Halt) begin
                seen = 1'b1;
                break;
            end
            step_pulse();
        end
        if (!seen) fail_now("halt_timeout", "got Halt=0 expected Halt=1 within budget");
        @(negedge Clock);
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_image(input logic [7:0] in_val, input bit chk_cyc);
        do_reset();
        load_image();
        check("load_full", loadFull, 1'b1);
        model_and_expect(in_val, chk_cyc);
        start_run();
        wait_halt(200);
    endtask

    task automatic gen_random();
        int op, ad;
        int ops[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 13};
        for (int i = 0; i < 9; i++) begin
            op = ops[$urandom_range(11, 0)];
            if (op == 7 || op == 8) ad = $urandom_range(9, i + 1);
            else ad = $urandom_range(15, 10);
            img[i] = 8'((op << 4) | ad);
        end
        img[9] = 8'hF0;
        for (int i = 10; i < 16; i++) begin
            case ($urandom_range(3, 0))
                0: img[i] = 8'h00;
                1: img[i] = 8'hFF;
                2: img[i] = 8'h01;
                default: img[i] = 8'($urandom_range(255, 0));
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit expected normal end");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        #1;
        check("rst_dataOut", dataOut, 8'h00);
        check("rst_state", CheckState, 3'd0);
        check("rst_halt", Halt, 1'b0);
        check("rst_zero", Zero, 1'b0);
        check("rst_carry", Carry, 1'b0);
        check("rst_loadFull", loadFull, 1'b0);

        // Scenario 1: LOAD10 / ADD11 / OUT / HALT
        img = '{8'h1A, 8'h3B, 8'h90, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h0A, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00};
        run_image(8'h00, 1'b1);
        check("s1_dataOut", dataOut, 8'h1E);
        check("s1_state", CheckState, 3'd4);

        // Scenario 2: 0xFF + 0x01 wraps to zero with carry, then SUB borrows
        img = '{8'h1A, 8'h3B, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        run_image(8'h00, 1'b1);
        check("s2_zero", Zero, 1'b1);
        check("s2_carry", Carry, 1'b1);
        img = '{8'h1A, 8'h3B, 8'h4C, 8'h90, 8'hF0, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
        run_image(8'h00, 1'b1);
        check("s2_sub_acc", dataOut, 8'hFF);
        check("s2_sub_carry", Carry, 1'b1);
        check("s2_sub_zero", Zero, 1'b0);

        // Scenario 3: JZ taken skips the OUT
        img = '{8'h1A, 8'h85, 8'h90, 8'hF0, 8'h00, 8'h0B, 8'hF0, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_image(8'h00, 1'b1);
        check("s3_no_out", dataOut, 8'h00);

        // Scenario 4: IN blocks until an Enter pulse
        img = '{8'hA0, 8'h90, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        load_image();
        model_and_expect(8'h5C, 1'b0);
        start_run();
        if (STEP) begin
            @(negedge Clock);
            step_pulse();
        end
        repeat (3) @(negedge Clock);
        check("s4_wait_early", CheckState, 3'd3);
        repeat (20) @(negedge Clock);
        check("s4_wait_late", CheckState, 3'd3);
        check("s4_hold_out", dataOut, 8'h00);
        data_in = 8'h5C;
        Enter = 1'b1;
        @(negedge Clock);
        Enter = 1'b0;
        wait_halt(100);
        check("s4_dataOut", dataOut, 8'h5C);

        // Scenario 5: 17 pulses fill memory; looping program then async reset mid-EXEC
        do_reset();
        img = '{8'h1F, 8'h90, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC3};
        for (int i = 0; i < 15; i++) pulse_word(img[i]);
        check("s5_not_full", loadFull, 1'b0);
        pulse_word(img[15]);
        check("s5_full", loadFull, 1'b1);
        pulse_word(8'h77);
        check("s5_still_full", loadFull, 1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            sb.push_back('{is_halt: 1'b0, dout: 8'hC3, z: 1'b0, c: 1'b0, ncyc: 0, chk_cyc: 1'b0});
            start_run();
            got = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge Clock);
                if (dataOut == 8'hC3 && CheckState == 3'd2) begin
                    got = 1'b1;
                    break;
                end
                step_pulse();
            end
            if (!got) fail_now("s5_exec_timeout", "got no EXEC with dataOut=0xC3 expected one");
            #2;
            Reset = 1'b0;
            #1;
            check("s5_rst_dataOut", dataOut, 8'h00);
            check("s5_rst_state", CheckState, 3'd0);
            check("s5_rst_halt", Halt, 1'b0);
            check("s5_rst_zero", Zero, 1'b0);
            check("s5_rst_carry", Carry, 1'b0);
            check("s5_rst_full", loadFull, 1'b0);
            check("s5_sb_drained", sb.size(), 0);
            sb.delete();
            repeat (2) @(negedge Clock);
            Reset = 1'b1;
        end

        // Randomised straight-line/forward-branch programs
        for (int t = 0; t < 40; t++) begin
            gen_random();
            run_image(8'h00, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
